full_pipeline_4: RTL and testbench
==================================

// Module: full_pipeline_4
// PURPOSE
//  Per-top accelerator core. Takes one 128-bit monotone function `top` (truth table over 7 vars)
//  and four candidate bots per beat (A, B=varSwap(5,6)(A), C, D=varSwap(5,6)(C)). For each valid
//  bot it counts connected components of graph G = top & ~bot in the 7-cube and adds 2^count into
//  a running 40-bit sum. Fed by the bot index provider; valid flags come from the subset checker.
// PARAMETERS
//  FIFO_DEPTH   16  input job queue entries (power of 2)
//  AF_MARGIN     4  almostFull asserted when occupancy >= FIFO_DEPTH-AF_MARGIN
//  SUM_W        40  width of summedDataOut
// PORTS
//  clk            in   1    single clock, all logic on rising edge
//  rst            in   1    asynchronous, active-high reset
//  top            in   128  top function; bit i = point i (var k = bit k of i)
//  botA           in   128  bot A; B derived internally
//  botC           in   128  bot C; D derived internally
//  botIndex       in   12   tag of the beat, stored with job (debug/trace only)
//  isBotValid     in   1    beat present; accepted when isBotValid && !full
//  validBotA..D   in   1    per-lane enable (bot subset of top); 0 -> lane contributes 0
//  full           out  1    queue has FIFO_DEPTH entries
//  almostFull     out  1    occupancy >= FIFO_DEPTH-AF_MARGIN; upstream stops requesting
//  summedDataOut  out  40   running sum of contributions, mod 2^40
// BEHAVIOUR
//  - Reset (async, rst=1): queue empty, lanes idle, summedDataOut=0, full=0, almostFull=0.
//  - varSwap(5,6)(X) = {X[127:96], X[63:32], X[95:64], X[31:0]}; applied at enqueue.
//  - Enqueue: on edge with isBotValid && !full push {top, A,B,C,D, 4 valid bits, botIndex}.
//    Beat offered while full is dropped (upstream must honour almostFull). Push and pop in the
//    same cycle are both performed; occupancy unchanged.
//  - Dispatch: when lanes idle and queue non-empty, head loads all 4 lanes next cycle;
//    lane graph R = top & ~bot if valid else lane marked done with contribution 0.
//  - Lane counter (per cycle): frontier F, remaining R, count n (7 bits):
//      F==0, R==0 -> done;  F==0, R!=0 -> F = lowest set bit of R, R &= ~F, n++;
//      F!=0 -> N = nbr(F) & R; R &= ~N; F = N.
//    nbr(F) = OR over k=0..6 of (F<<2^k masked to points with bit k=1) | (F>>2^k masked to bit k=0).
//  - Valid lane with empty graph: n=0, contributes 1. Contribution = 1<<n, n>=40 contributes 0.
//  - When all 4 lanes done: summedDataOut += sum of 4 contributions (mod 2^40, wraps silently),
//    job popped the same edge; next job dispatched following cycle. Latency variable (>=3 cycles).
//  - Queue order preserved; jobs processed strictly one at a time.
//  - rst asserted mid-job: job, queue and sum discarded immediately.
// STRUCTURE
//  - Package full_pipeline_pkg: SUM_W, FIFO_DEPTH defaults, job struct typedef, functions
//    var_swap_56(), nbr7() (hypercube neighbour with per-var masks), lowest_bit().
//  - Sub-module component_counter (instantiated x4): start, graph[127:0], enable in;
//    done, count[6:0] out. Top holds FIFO, dispatch and 40-bit accumulator.
// TESTING
//  - Reset release -> summedDataOut=0, full=0, almostFull=0 for all idle cycles.
//  - top=all 1s, botA=botC=all 1s, all valid -> 4 empty graphs -> summedDataOut=4.
//  - top=all 1s, botA=0, only validBotA -> 1 component -> +2.
//  - top bits 0 and 127 only, botA=0, validBotA,B -> 2 comps each (B=A) -> +8.
//  - top=odd-parity points (64 isolated), botA=0, validBotA -> n=64 -> +0; sum 2^40-1 +1 wraps to 0.
//  - Stream 20 beats with isBotValid held, lanes busy -> almostFull at 12, full at 16, no push
//    while full; final sum equals sum over accepted beats only; rst mid-job -> all outputs 0.

Source files
------------

// File: rtl/full_pipeline_pkg.sv
// full_pipeline_pkg: shared types, defaults and 7-cube helpers for the per-top accelerator core.
package full_pipeline_pkg;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_AF_MARGIN = 4;
  localparam int DEFAULT_SUM_W = 40;
  localparam int LANES = 4;
  typedef struct packed {
    logic [127:0] top;
    logic [LANES-1:0][127:0] bot;
    logic [LANES-1:0] valid;
    logic [11:0] botIndex;
  } jobT;
  // VAR_MASK[k] marks the points whose variable k is 1
  localparam logic [127:0] VAR_MASK [7] = '{
    {32{4'hA}},
    {32{4'hC}},
    {16{8'hF0}},
    {8{16'hFF00}},
    {4{32'hFFFF0000}},
    {2{64'hFFFFFFFF00000000}},
    {{64{1'b1}}, {64{1'b0}}}
  };
  function automatic logic [127:0] var_swap_56(input logic [127:0] x);
    return {x[127:96], x[63:32], x[95:64], x[31:0]};
  endfunction
  function automatic logic [127:0] nbr7(input logic [127:0] f);
    logic [127:0] n;
    n = '0;
    for (int k = 0; k < 7; k++)
      n = n | ((f << (1 << k)) & VAR_MASK[k]) | ((f >> (1 << k)) & ~VAR_MASK[k]);
    return n;
  endfunction
  function automatic logic [127:0] lowest_bit(input logic [127:0] x);
    return x & (~x + 128'd1);
  endfunction
endpackage

// File: rtl/component_counter.sv
// component_counter: counts connected components of a 7-cube subgraph by repeated flood fill.
module component_counter
  import full_pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] graph,
  input  logic         enable,
  output logic         done,
  output logic [6:0]   count
);
  logic [127:0] frontier, remaining, nbrs, seed;
  always_comb begin
    nbrs = nbr7(frontier) & remaining;
    seed = lowest_bit(remaining);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frontier <= '0;
      remaining <= '0;
      count <= '0;
      done <= 1'b1;
    end else if (start) begin
      frontier <= '0;
      remaining <= enable ? graph : '0;
      count <= '0;
      done <= !enable;
    end else if (!done) begin
      if (frontier == '0 && remaining == '0) begin
        done <= 1'b1;
      end else if (frontier == '0) begin
        frontier <= seed;
        remaining <= remaining & ~seed;
        count <= count + 7'd1;
      end else begin
        frontier <= nbrs;
        remaining <= remaining & ~nbrs;
      end
    end
  end
endmodule

// File: rtl/full_pipeline_4.sv
// full_pipeline_4: job queue feeding four component counters and a running 2^count accumulator.
module full_pipeline_4
  import full_pipeline_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AF_MARGIN = DEFAULT_AF_MARGIN,
  parameter int SUM_W = DEFAULT_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     top,
  input  logic [127:0]     botA,
  input  logic [127:0]     botC,
  input  logic [11:0]      botIndex,
  input  logic             isBotValid,
  input  logic             validBotA,
  input  logic             validBotB,
  input  logic             validBotC,
  input  logic             validBotD,
  output logic             full,
  output logic             almostFull,
  output logic [SUM_W-1:0] summedDataOut
);
  localparam int AW = $clog2(FIFO_DEPTH);
  jobT mem [FIFO_DEPTH];
  jobT inJob, head;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] occupancy;
  logic busy, push, pop, dispatch;
  logic [LANES-1:0] laneDone;
  logic [6:0] laneCount [LANES];
  logic [SUM_W-1:0] beatSum;
  function automatic logic [SUM_W-1:0] contribution(input logic [6:0] n);
    return n >= 7'(SUM_W) ? '0 : {{(SUM_W-1){1'b0}}, 1'b1} << n;
  endfunction
  assign inJob = '{top: top,
                   bot: {var_swap_56(botC), botC, var_swap_56(botA), botA},
                   valid: {validBotD, validBotC, validBotB, validBotA},
                   botIndex: botIndex};
  assign head = mem[rdPtr];
  assign full = occupancy == (AW+1)'(FIFO_DEPTH);
  assign almostFull = occupancy >= (AW+1)'(FIFO_DEPTH - AF_MARGIN);
  assign push = isBotValid && !full;
  assign pop = busy && (&laneDone);
  assign dispatch = !busy && occupancy != '0;
  // disabled lanes report count 0, so their contribution must be masked here
  always_comb begin
    beatSum = '0;
    for (int l = 0; l < LANES; l++)
      beatSum = beatSum + (head.valid[l] ? contribution(laneCount[l]) : '0);
  end
  for (genvar i = 0; i < LANES; i++) begin : gLane
    component_counter uCounter (
      .clk(clk),
      .rst(rst),
      .start(dispatch),
      .graph(head.top & ~head.bot[i]),
      .enable(head.valid[i]),
      .done(laneDone[i]),
      .count(laneCount[i])
    );
  end
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inJob;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occupancy <= '0;
      busy <= 1'b0;
      summedDataOut <= '0;
    end else begin
      wrPtr <= push ? wrPtr + 1'b1 : wrPtr;
      rdPtr <= pop ? rdPtr + 1'b1 : rdPtr;
      occupancy <= occupancy + (AW+1)'(push) - (AW+1)'(pop);
      busy <= dispatch ? 1'b1 : (pop ? 1'b0 : busy);
      summedDataOut <= pop ? summedDataOut + beatSum : summedDataOut;
    end
  end
endmodule

// File: tb/tb_full_pipeline_4.sv
// tb_full_pipeline_4: directed checks of component sums, swap lanes, wrap, queue flags and reset.
module tb_full_pipeline_4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] top = '0, botA = '0, botC = '0;
  logic [11:0] botIndex = '0;
  logic isBotValid = 1'b0, validBotA = 1'b0, validBotB = 1'b0, validBotC = 1'b0, validBotD = 1'b0;
  logic full, almostFull;
  logic [39:0] summedDataOut;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  full_pipeline_4 dut (
    .clk(clk), .rst(rst), .top(top), .botA(botA), .botC(botC), .botIndex(botIndex),
    .isBotValid(isBotValid), .validBotA(validBotA), .validBotB(validBotB),
    .validBotC(validBotC), .validBotD(validBotD), .full(full), .almostFull(almostFull),
    .summedDataOut(summedDataOut)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic setBeat(input logic [127:0] t, input logic [127:0] a, input logic [127:0] c,
                         input logic [3:0] v);
    top = t; botA = a; botC = c;
    {validBotD, validBotC, validBotB, validBotA} = v;
    botIndex = botIndex + 12'd1;
  endtask
  task automatic beat(input logic [127:0] t, input logic [127:0] a, input logic [127:0] c,
                      input logic [3:0] v);
    setBeat(t, a, c, v);
    isBotValid = 1'b1;
    @(negedge clk);
    isBotValid = 1'b0;
  endtask
  function automatic logic [127:0] isolated(input int n);
    logic [127:0] m;
    logic [6:0] p;
    int c;
    m = '0;
    c = 0;
    for (int i = 0; i < 128; i++) begin
      p = 7'(i);
      if (^p && c < n) begin
        m[i] = 1'b1;
        c++;
      end
    end
    return m;
  endfunction
  localparam logic [127:0] ONES = {128{1'b1}};
  initial begin
    logic [127:0] swapTop, swapBot;
    int accepted;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("resetSum", 64'(summedDataOut), 64'd0);
      check("resetFull", 64'(full), 64'd0);
      check("resetAf", 64'(almostFull), 64'd0);
    end
    beat(ONES, ONES, ONES, 4'b1111);
    idle(20);
    check("emptyGraphs", 64'(summedDataOut), 64'd4);
    beat(ONES, '0, ONES, 4'b0001);
    idle(30);
    check("oneComponent", 64'(summedDataOut), 64'd6);
    beat({1'b1, 126'b0, 1'b1}, '0, '0, 4'b0011);
    idle(30);
    check("twoCorners", 64'(summedDataOut), 64'd14);
    swapTop = {32'hFFFFFFFF, 32'h0, {64{1'b1}}};
    swapBot = {64'h0, 32'hFFFFFFFF, 32'h0};
    beat(swapTop, swapBot, swapBot, 4'b1111);
    idle(60);
    check("swapLanes", 64'(summedDataOut), 64'd26);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("resetClears", 64'(summedDataOut), 64'd0);
    for (int n = 0; n < 40; n++) begin
      beat(isolated(n), '0, '0, 4'b0001);
      idle(2 * n + 12);
      check($sformatf("build%0d", n), 64'(summedDataOut), (64'd1 << (n + 1)) - 64'd1);
    end
    beat(isolated(64), '0, '0, 4'b0001);
    idle(150);
    check("n64AddsZero", 64'(summedDataOut), 64'hFF_FFFF_FFFF);
    beat(ONES, ONES, '0, 4'b0001);
    idle(20);
    check("wrapToZero", 64'(summedDataOut), 64'd0);
    setBeat(isolated(64), '0, '0, 4'b0101);
    top = isolated(64) | ONES;
    top = ONES;
    botA = ~isolated(64);
    isBotValid = 1'b1;
    accepted = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      accepted = k > 16 ? 16 : k;
      check($sformatf("af%0d", k), 64'(almostFull), 64'(accepted >= 12));
      check($sformatf("full%0d", k), 64'(full), 64'(k >= 16));
    end
    isBotValid = 1'b0;
    idle(2600);
    check("streamSum", 64'(summedDataOut), 64'd32);
    check("drainedFull", 64'(full), 64'd0);
    check("drainedAf", 64'(almostFull), 64'd0);
    for (int i = 0; i < 14; i++) beat(ONES, ~isolated(64), '0, 4'b0001);
    idle(10);
    check("preResetSum", 64'(summedDataOut), 64'd32);
    check("preResetAf", 64'(almostFull), 64'd1);
    rst = 1'b1;
    #1;
    check("asyncSum", 64'(summedDataOut), 64'd0);
    check("asyncFull", 64'(full), 64'd0);
    check("asyncAf", 64'(almostFull), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(300);
    check("jobDiscarded", 64'(summedDataOut), 64'd0);
    check("queueDiscarded", 64'(almostFull), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
